// File: rtl/sccb_slave.sv
// SCCB camera-side responder: decodes ID / sub-address / data write cycles into a 256x8 register file.
// Optional SCCB_SLAVE_READ_EN adds the read-ID path (RDATA/RNA states).
module sccb_slave #(
  parameter logic [7:0] SLAVE_ID = 8'h42
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sioc,
  input  logic       i_siod,
  output logic       o_siod_oe,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  input  logic [7:0] i_rd_addr,
  output logic [7:0] o_rd_data
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK,
`ifdef SCCB_SLAVE_READ_EN
    RDATA, RNA,
`endif
    WAIT_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sioc_q, siod_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_data_q;
  logic        we;
  logic [7:0]  regs [256];
  logic [7:0]  bit_in;
  logic        sioc_rise, sioc_fall, start_det, stop_det;
`ifdef SCCB_SLAVE_READ_EN
  logic        rd_q, rd_d;
  logic [7:0]  ptr_byte;
  assign ptr_byte = regs[ptr_q];
`endif

  // Index 1 is the synchronized pin value, index 2 its one-cycle-delayed copy.
  assign sioc_rise = sioc_q[1] & ~sioc_q[2];
  assign sioc_fall = ~sioc_q[1] & sioc_q[2];
  assign start_det = sioc_q[1] & siod_q[2] & ~siod_q[1];
  assign stop_det  = sioc_q[1] & ~siod_q[2] & siod_q[1];
  assign bit_in    = {shift_q[6:0], siod_q[1]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    we         = 1'b0;
`ifdef SCCB_SLAVE_READ_EN
    rd_d       = rd_q;
`endif
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ID;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        ID, SUB, DATA: if (sioc_rise) begin
          shift_d = bit_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            unique case (state_q)
              ID: begin
                if (bit_in == SLAVE_ID) begin
                  state_d = ID_ACK;
`ifdef SCCB_SLAVE_READ_EN
                  rd_d    = 1'b0;
                end else if (bit_in == (SLAVE_ID | 8'h01)) begin
                  state_d = ID_ACK;
                  rd_d    = 1'b1;
`endif
                end else begin
                  state_d = WAIT_STOP;
                  cnt_d   = 4'd0;
                end
              end
              SUB: begin
                ptr_d   = bit_in;
                state_d = SUB_ACK;
              end
              default: begin
                we         = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = bit_in;
                state_d    = DATA_ACK;
              end
            endcase
          end
        end
        // Acknowledge: pull low on the first falling edge, release on the next one.
        ID_ACK, SUB_ACK, DATA_ACK: begin
          if (sioc_rise) cnt_d = cnt_q + 4'd1;
          if (sioc_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 4'd0;
              unique case (state_q)
                SUB_ACK:  state_d = DATA;
                DATA_ACK: state_d = WAIT_STOP;
                default: begin
                  state_d = SUB;
`ifdef SCCB_SLAVE_READ_EN
                  if (rd_q) begin
                    state_d = RDATA;
                    shift_d = ptr_byte;
                    oe_d    = ~ptr_byte[7];
                  end
`endif
                end
              endcase
            end
          end
        end
`ifdef SCCB_SLAVE_READ_EN
        RDATA: begin
          if (sioc_rise) cnt_d = cnt_q + 4'd1;
          if (sioc_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = RNA;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        RNA: if (sioc_rise) state_d = WAIT_STOP;
`endif
        WAIT_STOP: oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Idle bus level, so leaving reset never fakes a start or stop.
      sioc_q     <= 3'b111;
      siod_q     <= 3'b111;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      rd_data_q  <= 8'd0;
`ifdef SCCB_SLAVE_READ_EN
      rd_q       <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sioc_q     <= {sioc_q[1:0], i_sioc};
      siod_q     <= {siod_q[1:0], i_siod};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= regs[i_rd_addr];
`ifdef SCCB_SLAVE_READ_EN
      rd_q       <= rd_d;
`endif
    end
  end

  // NOTE: the register file has no reset so it maps onto plain RAM and survives a bus reset.
  always_ff @(posedge i_clk) begin
    if (we && !i_rst) regs[ptr_q] <= bit_in;
  end

  assign o_siod_oe  = oe_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;
  assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Self-checking bench for sccb_slave: an SCCB master model drives directed transactions; a
// monitor pops expected writes from a scoreboard queue whenever o_wr_valid is seen.
module tb_sccb_slave;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       sioc;
  logic       siod_m;
  logic       siod_bus;
  logic       oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         chk_old;
    logic [7:0] old;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  oe_hi_cnt = 0;

  assign siod_bus = siod_m & ~oe;

  sccb_slave #(.SLAVE_ID(8'h42)) dut (
    .i_clk(clk), .i_rst(rst), .i_sioc(sioc), .i_siod(siod_bus),
    .o_siod_oe(oe), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected write per o_wr_valid cycle.
  always @(negedge clk) begin
    if (oe) oe_hi_cnt++;
    if (!rst && wr_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious wr_valid", {31'd0, wr_valid}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        if (e.chk_old) check("read-first old data", {24'd0, rd_data}, {24'd0, e.old});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic sccb_start();
    siod_m = 1'b1; sioc = 1'b1; wait_clk(Q);
    siod_m = 1'b0; wait_clk(Q);
    sioc = 1'b0; wait_clk(Q);
  endtask

  task automatic sccb_stop();
    siod_m = 1'b0; wait_clk(Q);
    sioc = 1'b1; wait_clk(Q);
    siod_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b, output logic oe_seen);
    siod_m = b; wait_clk(Q);
    sioc = 1'b1; wait_clk(Q);
    oe_seen = oe; wait_clk(Q);
    sioc = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_oe);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
    send_bit(1'b1, ack_oe);
  endtask

  task automatic read_byte(output logic [7:0] r, output logic na_oe);
    for (int i = 7; i >= 0; i--) begin
      siod_m = 1'b1; wait_clk(Q);
      sioc = 1'b1; wait_clk(Q);
      r[i] = siod_bus; wait_clk(Q);
      sioc = 1'b0; wait_clk(Q);
    end
    send_bit(1'b1, na_oe);
  endtask

  task automatic write3(input logic [7:0] a, input logic [7:0] d, input string tag);
    logic ack;
    sccb_start();
    send_byte(8'h42, ack); check({tag, " ack id"}, {31'd0, ack}, 32'd1);
    send_byte(a, ack);     check({tag, " ack sub"}, {31'd0, ack}, 32'd1);
    send_byte(d, ack);     check({tag, " ack data"}, {31'd0, ack}, 32'd1);
    sccb_stop();
    wait_clk(Q);
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk); rd_addr = a;
    @(negedge clk); check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    logic       ack, dummy, na_oe;
    logic [7:0] r;
    int         oe_before;

    rst = 1'b1; sioc = 1'b1; siod_m = 1'b1; rd_addr = 8'h00;
    wait_clk(3);
    @(negedge clk);
    check("reset oe", {31'd0, oe}, 32'd0);
    check("reset wr_valid", {31'd0, wr_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset wr_addr/data", {16'd0, wr_addr, wr_data}, 32'd0);
    check("reset rd_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;
    wait_clk(Q);

    // Basic write cycle.
    exp_q.push_back('{addr: 8'h12, data: 8'h80, chk_old: 1'b0, old: 8'h00});
    write3(8'h12, 8'h80, "write");
    check("busy after stop", {31'd0, busy}, 32'd0);
    rd_check(8'h12, 8'h80, "rd 0x12 after write");

    // ID mismatch: no ack, no write, register untouched.
    oe_before = oe_hi_cnt;
    sccb_start();
    send_byte(8'h60, ack); check("mismatch ack", {31'd0, ack}, 32'd0);
    send_byte(8'h12, ack);
    send_byte(8'h55, ack);
    check("mismatch busy", {31'd0, busy}, 32'd1);
    sccb_stop();
    wait_clk(Q);
    check("mismatch oe never high", oe_hi_cnt - oe_before, 32'd0);
    rd_check(8'h12, 8'h80, "rd 0x12 after mismatch");

    // Aborted data phase.
    sccb_start();
    send_byte(8'h42, ack);
    send_byte(8'h3A, ack);
    for (int i = 0; i < 5; i++) send_bit(1'b1, dummy);
    check("abort busy mid", {31'd0, busy}, 32'd1);
    sccb_stop();
    wait_clk(Q);
    check("abort busy falls", {31'd0, busy}, 32'd0);
    check("abort wr_addr held", {24'd0, wr_addr}, 32'h12);

`ifdef SCCB_SLAVE_READ_EN
    exp_q.push_back('{addr: 8'h0A, data: 8'h76, chk_old: 1'b0, old: 8'h00});
    write3(8'h0A, 8'h76, "pre-read");
    sccb_start();
    send_byte(8'h42, ack);
    send_byte(8'h0A, ack); check("2-phase ack sub", {31'd0, ack}, 32'd1);
    sccb_stop();
    wait_clk(Q);
    sccb_start();
    send_byte(8'h43, ack); check("read ack id", {31'd0, ack}, 32'd1);
    read_byte(r, na_oe);
    check("read byte", {24'd0, r}, 32'h76);
    check("read NA released", {31'd0, na_oe}, 32'd0);
    sccb_stop();
    wait_clk(Q);
`else
    oe_before = oe_hi_cnt;
    sccb_start();
    send_byte(8'h43, ack); check("read id ignored", {31'd0, ack}, 32'd0);
    read_byte(r, na_oe);
    sccb_stop();
    wait_clk(Q);
    check("read bus never driven", oe_hi_cnt - oe_before, 32'd0);
`endif

    // Overwrite while reading the same address: same-cycle read returns old data.
    @(negedge clk); rd_addr = 8'h12;
    exp_q.push_back('{addr: 8'h12, data: 8'h3C, chk_old: 1'b1, old: 8'h80});
    write3(8'h12, 8'h3C, "overwrite");
    rd_check(8'h12, 8'h3C, "rd 0x12 after overwrite");

    // Reset after the 4th data bit.
    sccb_start();
    send_byte(8'h42, ack);
    send_byte(8'h05, ack);
    send_bit(1'b1, dummy); send_bit(1'b0, dummy); send_bit(1'b1, dummy); send_bit(1'b0, dummy);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midreset oe", {31'd0, oe}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset wr_addr/data", {16'd0, wr_addr, wr_data}, 32'd0);
    check("midreset rd_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;
    sccb_stop();
    wait_clk(Q);
    exp_q.push_back('{addr: 8'h01, data: 8'h5A, chk_old: 1'b0, old: 8'h00});
    write3(8'h01, 8'h5A, "post-reset");
    rd_check(8'h01, 8'h5A, "rd 0x01 after reset write");

    // Repeated start discards the first transaction.
    exp_q.push_back('{addr: 8'h21, data: 8'h33, chk_old: 1'b0, old: 8'h00});
    sccb_start();
    send_byte(8'h42, ack);
    send_byte(8'h20, ack);
    write3(8'h21, 8'h33, "rstart");
    rd_check(8'h21, 8'h33, "rd 0x21 after repeated start");

    wait_clk(4 * Q);
    check("pending writes", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_slave.md
# sccb_slave

Camera-side SCCB responder: emulates an OV7670 register interface so the camera-init master can be closed in loopback on the FPGA and in simulation. It detects start/stop on the sampled `sioc`/`siod` pins, decodes 3-phase write cycles (ID, sub-address, data) into a 256x8 register file, and presents a one-cycle write strobe per completed write. A side port reads the register file for verification.

## Interface

**Parameters**
- `SLAVE_ID`, default 8'h42: 7-bit ID plus write bit. The read ID is `SLAVE_ID | 1`.

**Ports**
- `i_clk`, in, 1: system clock, 100 MHz. Must be at least 10x the `sioc` frequency.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_sioc`, in, 1: SCCB clock pin, asynchronous.
- `i_siod`, in, 1: SCCB data pin, asynchronous. Undriven bus resolves to 1.
- `o_siod_oe`, out, 1: open-drain pull-down enable. 1 means the pad drives `siod` low.
- `o_wr_valid`, out, 1: one-cycle pulse when a 3-phase write completes.
- `o_wr_addr`, out, 8: register sub-address of the last write.
- `o_wr_data`, out, 8: data of the last write.
- `o_busy`, out, 1: 1 from start condition to stop condition.
- `i_rd_addr`, in, 8: register-file read address.
- `o_rd_data`, out, 8: register-file read data. Latency is 1 cycle.

## Operation

**Input conditioning**
- `i_sioc` and `i_siod` each pass through a 2-FF synchronizer.
- Edges are detected on the synchronized values against a third, delayed flop.
- Start condition: `siod` falls while `sioc` is 1.
- Stop condition: `siod` rises while `sioc` is 1.

**Bit protocol**
- Bits are sampled on the `sioc` rising edge, MSB first.
- Each phase is 8 bits plus a 9th don't-care bit.
- A 4-bit bit counter counts 0..8 and is cleared on start and at the end of each phase.

**States**
- IDLE: wait for start -> ID.
- ID: shift in 8 bits.
  - Byte equals `SLAVE_ID` -> ID_ACK(wr).
  - Byte equals `SLAVE_ID|1` -> ID_ACK(rd).
  - Otherwise -> WAIT_STOP.
- ID_ACK: 9th bit; the slave drives low. Then write path -> SUB; read path -> RDATA.
- SUB: shift 8 bits into the sub-address pointer `ptr` -> SUB_ACK.
- SUB_ACK: 9th bit, drive low -> DATA.
  - A stop condition here leaves `ptr` updated. This is a 2-phase write, used before a read.
- DATA: shift 8 bits; on the 8th bit, write `regs[ptr]` and pulse `o_wr_valid` -> DATA_ACK.
- DATA_ACK: 9th bit, drive low -> WAIT_STOP. Extra bytes are ignored; there is no auto-increment.
- RDATA: drive `regs[ptr]` MSB first. `o_siod_oe = ~bit`, updated on each `sioc` falling edge -> RNA.
- RNA: release the bus (`oe` = 0) for the master's NA bit -> WAIT_STOP.
- WAIT_STOP: `oe` = 0; wait for stop -> IDLE.

**Drive window**
- The 9th-bit drive is asserted on the `sioc` falling edge after bit 8 is sampled.
- It is released on the next `sioc` falling edge.

**Boundary conditions**
- Stop in any state -> IDLE, `oe` = 0. No write occurs unless DATA has completed all 8 bits.
- Start in any state (repeated start) -> ID, bit counter cleared, `oe` = 0. `ptr` is kept.
- ID mismatch: `o_siod_oe` never asserts for the rest of the transaction.
- A register-file write and an `i_rd_addr` read of the same address in the same cycle returns the old data (read-first).
- Reset mid-transaction -> IDLE, no write, `oe` = 0. The register-file contents are not reset.

## Timing

**Reset values**
- `o_siod_oe`=0, `o_wr_valid`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_busy`=0, `o_rd_data`=0.
- `ptr`=0, state IDLE.

**Latencies**
- Pin edge to internal edge detect: 3 `i_clk` cycles.
- `o_wr_valid` is high for exactly 1 cycle, on the cycle after the detect of the 8th DATA `sioc` rise.
  - `o_wr_addr` and `o_wr_data` are valid in that cycle and hold until the next write.
- `o_busy` rises 1 cycle after the start detect and falls 1 cycle after the stop detect.
- `o_siod_oe` changes 1 cycle after the `sioc` falling-edge detect, which is at least 3 `i_clk` cycles ahead of the next rise at 400 kHz.
- `o_rd_data`: registered 1 cycle after `i_rd_addr`.

## Configuration

`SCCB_SLAVE_READ_EN`
- Defined: the read ID is decoded and the RDATA and RNA states exist, per Operation.
- Undefined:
  - `SLAVE_ID|1` is treated as a mismatch -> WAIT_STOP; the bus is never driven during reads.
  - RDATA and RNA are compiled out.
  - The write path is unchanged.

## Test plan

- Write cycle: start, bytes 0x42, 0x12, 0x80, stop.
  - Required: exactly one `o_wr_valid` pulse with addr 0x12 and data 0x80.
  - Required: `o_siod_oe` high for each of the three 9th bits.
  - Required: `i_rd_addr`=0x12 gives 0x80 one cycle later.
- ID mismatch: start, bytes 0x60, 0x12, 0x55, stop.
  - Required: no `o_wr_valid`, `o_siod_oe` stays 0, and `regs[0x12]` is unchanged.
- Aborted data: start, 0x42, 0x3A, then 5 bits of 0xFF, then stop.
  - Required: no `o_wr_valid`, state returns to IDLE, and `o_busy` falls.
- Read (with `SCCB_SLAVE_READ_EN`): write 0x0A=0x76, then 2-phase 0x42, 0x0A, stop, then start, 0x43, and 8 clocks.
  - Required: the bus observed is 0x76 MSB first, with `oe` released on the NA bit.
- Reset mid-DATA: assert `i_rst` for 1 cycle after the 4th data bit.
  - Required: all outputs reach their reset values and there is no write.
  - Required: a following full write of 0x42, 0x01, 0x5A succeeds.
- Repeated start: start, 0x42, 0x20, then start, 0x42, 0x21, 0x33, stop.
  - Required: a single write with addr 0x21 and data 0x33.
